// File: rtl/zfh_mult_sched.sv
// FP16 multiplier core, pipeline stage register, and the round-robin scheduler
// that shares one core among NUM_REQ requesters.
`timescale 1ns/1ps

// Combinational FP16 multiply with round-to-nearest-even and subnormal support.
// Any NaN input, and Inf*0, produce the canonical quiet NaN 0x7E00.
module zfh_fp16_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sgn, nan_in, inf_a, inf_b, zero_a, zero_b;
    logic [4:0]        ea, eb, lead;
    logic [10:0]       ma, mb, q;
    logic [21:0]       prod;
    logic signed [8:0] e_val, e_cl, rs;
    logic [5:0]        sh;
    logic [63:0]       ext;
    logic              guard, sticky, rnd;
    logic [11:0]       mant;
    logic [16:0]       mag;

    // Decode, multiply significands, normalise/denormalise, round, re-encode.
    always_comb begin
        sgn    = a[15] ^ b[15];
        ea     = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
        eb     = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
        ma     = {a[14:10] != 5'd0, a[9:0]};
        mb     = {b[14:10] != 5'd0, b[9:0]};
        nan_in = (&a[14:10] & |a[9:0]) | (&b[14:10] & |b[9:0]);
        inf_a  = &a[14:10] & ~|a[9:0];
        inf_b  = &b[14:10] & ~|b[9:0];
        zero_a = ~|a[14:0];
        zero_b = ~|b[14:0];
        prod   = 22'(ma) * 22'(mb);
        lead   = '0;
        for (int i = 0; i < 22; i++)
            if (prod[i]) lead = 5'(i);
        // Biased exponent the leading one would carry; below 1 means subnormal.
        e_val  = $signed({4'd0, lead}) + $signed({4'd0, ea}) + $signed({4'd0, eb}) - 9'sd35;
        e_cl   = (e_val < 9'sd1) ? 9'sd1 : e_val;
        // Right shift that puts the leading one at bit 10 (or lower if subnormal).
        rs     = $signed({4'd0, lead}) - 9'sd10 + (e_cl - e_val);
        sh     = (rs > 9'sd28) ? 6'd40 : 6'(rs + 9'sd12);
        ext    = {30'd0, prod, 12'd0};
        q      = 11'(ext >> sh);
        guard  = ext[sh - 6'd1];
        sticky = |(ext & ((64'd1 << (sh - 6'd1)) - 64'd1));
        rnd    = guard & (sticky | q[0]);
        mant   = {1'b0, q} + {11'd0, rnd};
        // Hidden bit adds into the exponent field, so rounding carries for free.
        mag    = (17'(e_cl - 9'sd1) << 10) + 17'(mant);
        if (nan_in || (inf_a && zero_b) || (zero_a && inf_b)) y = 16'h7E00;
        else if (inf_a || inf_b)                             y = {sgn, 15'h7C00};
        else if (prod == 22'd0)                              y = {sgn, 15'd0};
        else if (mag >= 17'h07C00)                           y = {sgn, 15'h7C00};
        else                                                 y = {sgn, mag[14:0]};
    end
endmodule

// One enabled pipeline register, cleared by synchronous reset.
module zfh_mult_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Load when the pipeline advances, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

// Round-robin scheduler feeding one shared FP16 multiplier through a
// PIPE_STAGES-deep stall-as-a-whole pipeline.
module zfh_mult_sched #(
    parameter  int NUM_REQ     = 2,
    parameter  int PIPE_STAGES = 2,
    parameter  int TAG_W       = 4,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][15:0]        req_a,
    input  logic [NUM_REQ-1:0][15:0]        req_b,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [15:0]                     rsp_data,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [TAG_W-1:0]                rsp_tag,
    output logic                            busy
);
    typedef struct packed {
        logic             vld;
        logic [15:0]      data;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t               st_d [PIPE_STAGES];
    stage_t               st_q [PIPE_STAGES];
    logic [PIPE_STAGES:0] vld_pipe;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      gnt_idx, rr_ptr;
    logic [ID_W:0]        cand;
    logic                 any_req, advance, accept;
    logic [15:0]          product;

    // A full output slot that is not being drained freezes every stage.
    assign advance   = ~st_q[PIPE_STAGES-1].vld | rsp_ready;
    assign accept    = any_req & advance & ~RST;
    assign req_ready = grant & {NUM_REQ{advance & ~RST}};

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(j);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (!any_req && req_valid[cand[ID_W-1:0]]) begin
                any_req = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        if (any_req) grant[gnt_idx] = 1'b1;
    end

    zfh_fp16_mul u_core (
        .a (req_a[gnt_idx]),
        .b (req_b[gnt_idx]),
        .y (product)
    );

    // Stage inputs: granted op enters s[0], everything else shifts by one.
    always_comb begin
        vld_pipe    = '0;
        vld_pipe[0] = accept;
        for (int k = 0; k < PIPE_STAGES; k++) vld_pipe[k+1] = st_q[k].vld;
        st_d[0] = '{vld: vld_pipe[0], data: product, id: gnt_idx, tag: req_tag[gnt_idx]};
        for (int k = 1; k < PIPE_STAGES; k++) st_d[k] = st_q[k-1];
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        zfh_mult_stage #(.W($bits(stage_t))) u_stage (
            .clk (CLK),
            .rst (RST),
            .en  (advance),
            .d   (st_d[k]),
            .q   (st_q[k])
        );
    end

    // Pointer moves just past the requester that was accepted.
    always_ff @(posedge CLK) begin
        if (RST)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    assign rsp_valid = st_q[PIPE_STAGES-1].vld;
    assign rsp_data  = st_q[PIPE_STAGES-1].data;
    assign rsp_id    = st_q[PIPE_STAGES-1].id;
    assign rsp_tag   = st_q[PIPE_STAGES-1].tag;
    assign busy      = |vld_pipe[PIPE_STAGES:1];
endmodule

// File: tb/tb_zfh_mult_sched.sv
// Randomised bench for zfh_mult_sched: a queue-based model of in-flight ops
// plus a real-arithmetic FP16 reference, checked on every clock.
`timescale 1ns/1ps

module tb_zfh_mult_sched;
    localparam int N = 2, P = 2, TW = 4;

    logic               CLK = 1'b0, RST = 1'b1;
    logic [N-1:0]       req_valid = '0, req_ready;
    logic [N-1:0][15:0] req_a = '0, req_b = '0;
    logic [N-1:0][TW-1:0] req_tag = '0;
    logic               rsp_valid, rsp_ready = 1'b1, busy;
    logic [15:0]        rsp_data;
    logic [0:0]         rsp_id;
    logic [TW-1:0]      rsp_tag;

    zfh_mult_sched #(.NUM_REQ(N), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- FP16 reference via exact real arithmetic ----
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag16(input logic [15:0] x);
        if (x[14:10] == 5'd0) return real'(int'(x[9:0])) * pow2(-24);
        return real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic s = a[15] ^ b[15];
        logic an = (a[14:10] == 5'h1F) && (a[9:0] != 0), bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        logic ai = (a[14:0] == 15'h7C00), bi = (b[14:0] == 15'h7C00);
        logic az = (a[14:0] == 0), bz = (b[14:0] == 0);
        real m, sc, fr;
        int e, ip, bits;
        if (an || bn || (ai && bz) || (az && bi)) return 16'h7E00;
        if (ai || bi) return {s, 15'h7C00};
        m = mag16(a) * mag16(b);
        if (m == 0.0) return {s, 15'h0};
        e = -14;
        while (m >= pow2(e + 1)) e++;
        sc = m * pow2(10 - e);
        ip = $rtoi(sc);
        fr = sc - real'(ip);
        if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
        bits = (e + 14) * 1024 + ip;
        if (bits >= 'h7C00) return {s, 15'h7C00};
        return {s, 15'(bits)};
    endfunction

    // ---- behavioural scheduler model: in-flight ops with advance counts ----
    typedef struct { logic [15:0] d; int id; logic [TW-1:0] tag; int cnt; } op_t;
    typedef struct { int id; int tag; int cyc; } log_t;
    op_t  mq[$];
    log_t rlog[$];
    int   ptr = 0;
    bit   chk_en = 0;

    always @(negedge CLK) begin
        bit ev, adv;
        int g, idx;
        if (chk_en) begin
            ev = (mq.size() > 0) && (mq[0].cnt == P - 1);
            chk("rsp_valid", rsp_valid, ev);
            chk("busy", busy, mq.size() > 0);
            if (ev && rsp_valid) begin
                chk("rsp_data", rsp_data, mq[0].d);
                chk("rsp_id", rsp_id, mq[0].id);
                chk("rsp_tag", rsp_tag, mq[0].tag);
            end
            adv = !ev || rsp_ready;
            g = -1;
            if (!RST && adv)
                for (int j = 0; j < N; j++) begin
                    idx = (ptr + j) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (RST) begin
                mq.delete();
                ptr = 0;
            end else begin
                if (rsp_valid && rsp_ready) rlog.push_back('{int'(rsp_id), int'(rsp_tag), cyc});
                if (adv) begin
                    if (ev) void'(mq.pop_front());
                    foreach (mq[k]) mq[k].cnt = mq[k].cnt + 1;
                    if (g >= 0) begin
                        mq.push_back('{ref_mul(req_a[g], req_b[g]), g, req_tag[g], 0});
                        ptr = (g + 1) % N;
                    end
                end
            end
        end
        if (RST) chk_en = 1;
    end

    // ---- stimulus ----
    int           left[N];
    logic [TW-1:0] nt[N];
    logic [TW-1:0] tstep = 4'd1;
    bit           rand_mode = 0;
    logic [N-1:0] acc;

    function automatic logic [15:0] rand_fp16();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(7, 0))
            0: return {r[15], 15'h0};
            1: return {r[15], 15'h7C00};
            2: return {r[15], 5'h1F, 1'b1, r[8:0]};
            3: return {r[15], 5'h0, r[9:0]};
            4: return {r[15], 5'(12 + r[12:10]), r[9:0]};
            default: return r;
        endcase
    endfunction

    task automatic arm();
        for (int i = 0; i < N; i++)
            if (left[i] > 0 && !req_valid[i] && (!rand_mode || $urandom_range(3, 0) != 0)) begin
                req_a[i]     = rand_fp16();
                req_b[i]     = rand_fp16();
                req_tag[i]   = nt[i];
                nt[i]        = nt[i] + tstep;
                req_valid[i] = 1'b1;
            end
    endtask

    task automatic cycle_go();
        @(negedge CLK);
        acc = req_valid & req_ready;
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                left[i]--;
            end
        if (rand_mode) rsp_ready = ($urandom_range(2, 0) != 0);
        arm();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        left = '{0, 0};
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b0;
        rlog.delete();
    endtask

    task automatic chk_log(input string name, input int n, input int ids[], input int tags[]);
        chk({name, " count"}, rlog.size(), n);
        for (int k = 0; k < rlog.size() && k < n; k++) begin
            chk({name, " id"}, rlog[k].id, ids[k]);
            chk({name, " tag"}, rlog[k].tag, tags[k]);
        end
    endtask

    initial begin
        logic [15:0] cd;
        logic [3:0]  ct;
        logic [0:0]  ci;
        int budget, n0;

        // Hand-computed products pin the reference model.
        chk("ref 1.0*2.0", ref_mul(16'h3C00, 16'h4000), 16'h4000);
        chk("ref 1.5*1.5", ref_mul(16'h3E00, 16'h3E00), 16'h4080);
        chk("ref -2*3", ref_mul(16'hC000, 16'h4200), 16'hC600);
        chk("ref inf*0", ref_mul(16'h7C00, 16'h0000), 16'h7E00);
        chk("ref overflow", ref_mul(16'h7BFF, 16'h4000), 16'h7C00);
        chk("ref subnormal", ref_mul(16'h0001, 16'h3C00), 16'h0001);
        chk("ref rne", ref_mul(16'h3C01, 16'h3C01), 16'h3C02);
        chk("ref underflow", ref_mul(16'h0001, 16'h8001), 16'h8000);

        // Reset with every requester asserting valid.
        RST = 1'b1;
        req_valid = '1;
        repeat (3) begin @(posedge CLK); #1; end
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_tag", rsp_tag, 0);
        chk("reset busy", busy, 0);
        RST = 1'b0;
        #1;
        chk("first grant", req_ready, 2'b01);
        req_valid = '0;

        // Single op: 1.0 * 0.0, tag 5.
        do_reset();
        rsp_ready = 1'b1;
        left = '{1, 0};
        req_a[0] = 16'h3C00; req_b[0] = 16'h0000; req_tag[0] = 4'h5; req_valid[0] = 1'b1;
        cycle_go();
        chk("single accept", acc, 2'b01);
        chk("single busy c1", busy, 1);
        chk("single valid c1", rsp_valid, 0);
        cycle_go();
        chk("single valid c2", rsp_valid, 1);
        chk("single data", rsp_data, 16'h0000);
        chk("single id", rsp_id, 0);
        chk("single tag", rsp_tag, 4'h5);
        chk("single busy c2", busy, 1);
        cycle_go();
        chk("single idle c3", {rsp_valid, busy}, 2'b00);

        // Round-robin with both requesters continuously valid.
        do_reset();
        nt = '{4'd1, 4'd2}; tstep = 4'd2; left = '{3, 3};
        arm();
        for (int c = 0; c < 12 && (left[0] > 0 || left[1] > 0); c++) cycle_go();
        repeat (4) cycle_go();
        chk_log("rr", 6, '{0, 1, 0, 1, 0, 1}, '{1, 2, 3, 4, 5, 6});
        for (int k = 1; k < rlog.size(); k++) chk("rr back-to-back", rlog[k].cyc - rlog[k-1].cyc, 1);

        // Backpressure: fill the pipe, stall 4 cycles, then drain.
        do_reset();
        rsp_ready = 1'b0;
        nt = '{4'd1, 4'd2}; left = '{2, 2};
        arm();
        cycle_go();
        cycle_go();
        cd = rsp_data; ci = rsp_id; ct = rsp_tag;
        chk("bp head id", ci, 0);
        chk("bp head tag", ct, 4'd1);
        repeat (4) begin
            chk("bp req_ready", req_ready, 0);
            chk("bp hold data", rsp_data, cd);
            chk("bp hold id", rsp_id, ci);
            chk("bp hold tag", rsp_tag, ct);
            cycle_go();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 12 && (left[0] > 0 || left[1] > 0); c++) cycle_go();
        repeat (5) cycle_go();
        chk_log("bp drain", 4, '{0, 1, 0, 1}, '{1, 2, 3, 4});

        // Reset with two ops in flight.
        do_reset();
        rsp_ready = 1'b0;
        nt = '{4'd7, 4'd9}; left = '{1, 1};
        arm();
        cycle_go();
        cycle_go();
        chk("mid busy before", busy, 1);
        RST = 1'b1;
        cycle_go();
        RST = 1'b0;
        chk("mid rsp_valid", rsp_valid, 0);
        chk("mid busy", busy, 0);
        rsp_ready = 1'b1;
        repeat (6) cycle_go();
        chk("mid dropped", rlog.size(), 0);

        // Random traffic with random backpressure.
        do_reset();
        rand_mode = 1;
        tstep = 4'd1;
        nt = '{4'($urandom), 4'($urandom)};
        left = '{500, 500};
        arm();
        budget = 0;
        while ((left[0] > 0 || left[1] > 0 || mq.size() > 0) && budget < 20000) begin
            cycle_go();
            budget++;
        end
        chk("random in budget", budget < 20000, 1);
        chk("random count", rlog.size(), 1000);
        n0 = 0;
        foreach (rlog[k]) if (rlog[k].id == 0) n0++;
        chk("random req0 count", n0, 500);
        rand_mode = 0;
        rsp_ready = 1'b1;
        repeat (3) cycle_go();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
